dtw_mem_master: RTL and testbench

Bus master for the shared single-port 1024x32 data memory used by the DTW processor. It turns burst read and write commands from the DTW core into cycles on the memory bus: active-low chip select, write strobe, 10-bit address and a bidirectional 32-bit data bus. It sits between the DTW datapath and the memory, and is the only driver of the memory control lines and the only master-side driver of the data bus.

---
 rtl/dtw_mem_master_if.sv | 32 +++
 rtl/dtw_mem_master.sv | 138 +++++++++++++
 tb/tb_dtw_mem_master.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dtw_mem_master_if.sv
// rtl/dtw_mem_master_if.sv - command, write-data, read-data and memory control signals of dtw_mem_master
// The core side uses the master modport; dtw_mem_master uses the slave modport.
interface dtw_mem_master_if #(
  parameter int AW   = 10,
  parameter int DW   = 32,
  parameter int LENW = 4
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_we;
  logic [AW-1:0]   cmd_addr;
  logic [LENW-1:0] cmd_len;
  logic            wd_valid;
  logic            wd_ready;
  logic [DW-1:0]   wd_data;
  logic            rd_valid;
  logic [DW-1:0]   rd_data;
  logic            rd_last;
  logic [AW-1:0]   mem_addr;
  logic            mem_WR;
  logic            mem_CS;

  modport master (
    output cmd_valid, cmd_we, cmd_addr, cmd_len, wd_valid, wd_data,
    input  cmd_ready, wd_ready, rd_valid, rd_data, rd_last, mem_addr, mem_WR, mem_CS
  );

  modport slave (
    input  cmd_valid, cmd_we, cmd_addr, cmd_len, wd_valid, wd_data,
    output cmd_ready, wd_ready, rd_valid, rd_data, rd_last, mem_addr, mem_WR, mem_CS
  );
endinterface

// File: rtl/dtw_mem_master.sv
// rtl/dtw_mem_master.sv - burst bus master for the shared single-port 1024x32 DTW data memory
// Reads pipeline one address per cycle; writes present each accepted beat on the following cycle.
module dtw_mem_master #(
  parameter int AW   = 10,
  parameter int DW   = 32,
  parameter int LENW = 4
) (
  input  logic              clk,
  input  logic              nrst,
  dtw_mem_master_if.slave   bus,
  inout  wire  [DW-1:0]     mem_data
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_TAIL,
    ST_WR,
    ST_WR_END
  } state_e;

  state_e          state_q;
  logic [AW-1:0]   addr_q;
  logic [AW-1:0]   wptr_q;
  logic [LENW-1:0] cnt_q;
  logic            cs_n_q;
  logic            wr_q;
  logic            oe_q;
  logic            first_q;
  logic [DW-1:0]   dout_q;
  logic [DW-1:0]   rd_data_q;
  logic            rd_valid_q;
  logic            rd_last_q;

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.wd_ready  = (state_q == ST_WR);
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_last   = rd_last_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_WR    = wr_q;
  assign bus.mem_CS    = cs_n_q;

  // The bus is only driven from the registered enable, which is set solely for write-strobe cycles.
  assign mem_data = oe_q ? dout_q : {DW{1'bz}};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wptr_q     <= '0;
      cnt_q      <= '0;
      cs_n_q     <= 1'b1;
      wr_q       <= 1'b0;
      oe_q       <= 1'b0;
      first_q    <= 1'b0;
      dout_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cs_n_q <= 1'b1;
          wr_q   <= 1'b0;
          oe_q   <= 1'b0;
          if (bus.cmd_valid) begin
            addr_q <= bus.cmd_addr;
            wptr_q <= bus.cmd_addr;
            cnt_q  <= bus.cmd_len;
            if (bus.cmd_we) begin
              state_q <= ST_WR;
            end else begin
              state_q <= ST_RD;
              cs_n_q  <= 1'b0;
              first_q <= 1'b1;
            end
          end
        end
        ST_RD: begin
          // The first address cycle has nothing on the bus yet; every later one returns the previous word.
          first_q <= 1'b0;
          if (!first_q) begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= mem_data;
          end
          if (cnt_q == '0) begin
            state_q <= ST_RD_TAIL;
          end else begin
            addr_q <= addr_q + 1'b1;
            cnt_q  <= cnt_q - 1'b1;
          end
        end
        ST_RD_TAIL: begin
          rd_valid_q <= 1'b1;
          rd_last_q  <= 1'b1;
          rd_data_q  <= mem_data;
          cs_n_q     <= 1'b1;
          state_q    <= ST_IDLE;
        end
        ST_WR: begin
          if (bus.wd_valid) begin
            cs_n_q <= 1'b0;
            wr_q   <= 1'b1;
            oe_q   <= 1'b1;
            dout_q <= bus.wd_data;
            addr_q <= wptr_q;
            wptr_q <= wptr_q + 1'b1;
            if (cnt_q == '0) begin
              state_q <= ST_WR_END;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end else begin
            cs_n_q <= 1'b1;
            wr_q   <= 1'b0;
            oe_q   <= 1'b0;
          end
        end
        ST_WR_END: begin
          cs_n_q  <= 1'b1;
          wr_q    <= 1'b0;
          oe_q    <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          cs_n_q  <= 1'b1;
          wr_q    <= 1'b0;
          oe_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dtw_mem_master.sv
// tb/tb_dtw_mem_master.sv - directed bench for dtw_mem_master with a memory model and a reference scoreboard
// The reference memory and expected-beat queues are filled from the commands the bench issues.
module tb_dtw_mem_master;

  logic clk;
  logic nrst;
  logic preload;
  logic idle_chk;
  wire [31:0] mem_data;

  dtw_mem_master_if #(.AW(10), .DW(32), .LENW(4)) bus ();

  dtw_mem_master #(.AW(10), .DW(32), .LENW(4)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .bus      (bus.slave),
    .mem_data (mem_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem_arr [1024];
  logic [31:0] mem_q;
  logic [31:0] ref_mem [1024];

  logic [31:0] rexp_d [$];
  bit          rexp_l [$];
  logic [9:0]  wexp_a [$];
  logic [31:0] wexp_d [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory: registered read data driven while selected for read, write on strobe.
  assign mem_data = (!bus.mem_CS && !bus.mem_WR) ? mem_q : 32'bz;

  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 1024; k++) mem_arr[k] <= 32'h1000 + 32'(k);
    end else begin
      if (!bus.mem_CS && !bus.mem_WR) mem_q <= mem_arr[bus.mem_addr];
      if (!bus.mem_CS && bus.mem_WR)  mem_arr[bus.mem_addr] <= mem_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the scoreboard queues.
  always @(negedge clk) begin
    if (!nrst) begin
      check("rst_cs", 32'(bus.mem_CS), 32'd1);
      check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
      check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check("rst_wd_ready", 32'(bus.wd_ready), 32'd0);
    end else begin
      if (idle_chk) begin
        check("idle_cs", 32'(bus.mem_CS), 32'd1);
        check("idle_wd_ready", 32'(bus.wd_ready), 32'd0);
      end
      if (bus.rd_valid) begin
        if (rexp_d.size() == 0) begin
          check("rd_spurious", 32'(bus.rd_valid), 32'd0);
        end else begin
          check("rd_data", bus.rd_data, rexp_d.pop_front());
          check("rd_last", 32'(bus.rd_last), 32'(rexp_l.pop_front()));
        end
      end
      if (!bus.mem_CS && bus.mem_WR) begin
        if (wexp_d.size() == 0) begin
          check("wr_spurious", 32'(bus.mem_WR), 32'd0);
        end else begin
          check("wr_addr", 32'(bus.mem_addr), 32'(wexp_a.pop_front()));
          check("wr_data", mem_data, wexp_d.pop_front());
        end
      end
    end
  end

  task automatic issue_cmd(input bit we, input logic [9:0] a, input logic [3:0] len);
    int w;
    w = 0;
    while (!bus.cmd_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_addr  = a;
    bus.cmd_len   = len;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'($urandom);
    bus.cmd_addr  = 10'($urandom);
    bus.cmd_len   = 4'($urandom);
    check("cmd_ready_busy", 32'(bus.cmd_ready), 32'd0);
  endtask

  task automatic wr_burst(input logic [9:0] a, input int n, input logic [31:0] base, input bit stall,
                          output int done, output int gaps);
    int i;
    int k;
    bit hs;
    logic [9:0] ad;
    issue_cmd(1'b1, a, 4'(n - 1));
    i = 0; k = 0; gaps = 0; done = -1;
    for (int j = 1; j <= 80 && done < 0; j++) begin
      if (i < n) begin
        bus.wd_valid = stall ? (k % 2 == 0) : 1'b1;
        bus.wd_data  = base + 32'(i);
      end else begin
        bus.wd_valid = 1'b0;
      end
      hs = bus.wd_valid && bus.wd_ready;
      @(posedge clk); #1;
      if (hs) begin
        ad = a + 10'(i);
        wexp_a.push_back(ad);
        wexp_d.push_back(base + 32'(i));
        ref_mem[ad] = base + 32'(i);
        check("wr_beat_cs", 32'(bus.mem_CS), 32'd0);
        i++;
      end else if (i > 0 && i < n) begin
        gaps++;
        check("wr_gap_cs", 32'(bus.mem_CS), 32'd1);
      end
      k++;
      if (bus.cmd_ready) done = j;
    end
    bus.wd_valid = 1'b0;
    check("wr_beats_taken", 32'(i), 32'(n));
  endtask

  task automatic rd_burst(input logic [9:0] a, input int n, output logic [31:0] first_d,
                          output int nbeats, output int nlast);
    int first_j;
    int done_j;
    issue_cmd(1'b0, a, 4'(n - 1));
    for (int i = 0; i < n; i++) begin
      rexp_d.push_back(ref_mem[a + 10'(i)]);
      rexp_l.push_back(i == n - 1);
    end
    first_j = -1; done_j = -1; nbeats = 0; nlast = 0; first_d = '0;
    for (int j = 1; j <= 60 && done_j < 0; j++) begin
      @(posedge clk); #1;
      if (bus.rd_valid) begin
        if (first_j < 0) begin
          first_j = j;
          first_d = bus.rd_data;
        end
        nbeats++;
        if (bus.rd_last) nlast++;
      end
      if (bus.cmd_ready) done_j = j;
    end
    check("rd_first_latency", 32'(first_j), 32'd2);
    check("rd_done_latency", 32'(done_j), 32'(n + 1));
  endtask

  initial begin
    logic [31:0] fd;
    int nb, nl, nb2, nl2, done, gaps, seen;
    bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wd_valid = 1'b0;  bus.wd_data = '0;
    idle_chk = 1'b0;
    preload  = 1'b0;
    for (int k = 0; k < 1024; k++) ref_mem[k] = 32'h1000 + 32'(k);
    nrst = 1'b1;
    #1 nrst = 1'b0;
    preload = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    preload = 1'b0;
    nrst = 1'b1;

    // Idle with random, unqualified command and write-data fields.
    idle_chk = 1'b1;
    repeat (8) begin
      bus.cmd_we   = 1'($urandom);
      bus.cmd_addr = 10'($urandom);
      bus.cmd_len  = 4'($urandom);
      bus.wd_valid = 1'($urandom);
      bus.wd_data  = $urandom;
      @(posedge clk); #1;
    end
    idle_chk = 1'b0;
    bus.wd_valid = 1'b0;

    // Single-beat read.
    rd_burst(10'd20, 1, fd, nb, nl);
    check("single_rd_data", fd, 32'h0000_1014);
    check("single_rd_beats", 32'(nb), 32'd1);
    check("single_rd_last", 32'(nl), 32'd1);

    // 20 words as a 16 + 4 split, written then read back.
    wr_burst(10'd20, 16, 32'hA000_0000, 1'b0, done, gaps);
    check("wr16_done", 32'(done), 32'd17);
    wr_burst(10'd36, 4, 32'hA000_0010, 1'b0, done, gaps);
    check("wr4_done", 32'(done), 32'd5);
    rd_burst(10'd20, 16, fd, nb, nl);
    check("rd20_first", fd, 32'hA000_0000);
    rd_burst(10'd36, 4, fd, nb2, nl2);
    check("rd20_second_first", fd, 32'hA000_0010);
    check("rd20_beats", 32'(nb + nb2), 32'd20);
    check("rd20_lasts", 32'(nl + nl2), 32'd2);

    // Write with wd_valid low every other cycle.
    wr_burst(10'd100, 4, 32'hB000_0000, 1'b1, done, gaps);
    check("bp_done", 32'(done), 32'd8);
    check("bp_gaps", 32'(gaps), 32'd3);
    @(posedge clk); #1;
    check("bp_mem100", mem_arr[100], 32'hB000_0000);
    check("bp_mem101", mem_arr[101], 32'hB000_0001);
    check("bp_mem102", mem_arr[102], 32'hB000_0002);
    check("bp_mem103", mem_arr[103], 32'hB000_0003);

    // Address wrap at the top of memory.
    wr_burst(10'd1022, 4, 32'd1, 1'b0, done, gaps);
    @(posedge clk); #1;
    check("wrap_mem1022", mem_arr[1022], 32'd1);
    check("wrap_mem1023", mem_arr[1023], 32'd2);
    check("wrap_mem0", mem_arr[0], 32'd3);
    check("wrap_mem1", mem_arr[1], 32'd4);
    rd_burst(10'd1022, 4, fd, nb, nl);
    check("wrap_rd_first", fd, 32'd1);
    check("wrap_rd_beats", 32'(nb), 32'd4);

    // Reset during beat 5 of a 16-beat read.
    issue_cmd(1'b0, 10'd20, 4'd15);
    for (int i = 0; i < 16; i++) begin
      rexp_d.push_back(ref_mem[10'(20 + i)]);
      rexp_l.push_back(i == 15);
    end
    seen = 0;
    for (int j = 0; j < 40 && seen < 5; j++) begin
      @(posedge clk); #1;
      if (bus.rd_valid) seen++;
    end
    check("rst_mid_reached", 32'(seen), 32'd5);
    nrst = 1'b0;
    #1;
    check("rst_mid_cs", 32'(bus.mem_CS), 32'd1);
    check("rst_mid_rd_valid", 32'(bus.rd_valid), 32'd0);
    rexp_d.delete(); rexp_l.delete();
    wexp_a.delete(); wexp_d.delete();
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.rd_valid) seen++;
    end
    check("rst_mid_no_rd", 32'(seen), 32'd0);
    rd_burst(10'd20, 16, fd, nb, nl);
    check("rst_after_first", fd, 32'hA000_0000);
    check("rst_after_beats", 32'(nb), 32'd16);

    repeat (3) @(posedge clk);
    #1;
    check("end_rd_queue_empty", 32'(rexp_d.size()), 32'd0);
    check("end_wr_queue_empty", 32'(wexp_d.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
